// File: rtl/softmax_ctrl.sv
// Softmax sequencing controller: max scan, exp pass with saturating sum, divide pass.
// Drives a shared single-read/single-write memory and external exp/div units.
//
// state | meaning
// IDLE  | waiting for start; parameters sampled here only
// MAX   | stream N elements from raddr, track signed maximum
// EXP   | stream elements again, feed x-max to exp unit, store results at waddr, accumulate sum
// DIV   | stream stored exp values, feed num/sum to div unit, overwrite results at waddr
// DONE  | one-cycle completion, pulses done on the way back to IDLE
module softmax_ctrl #(
    parameter int AW = 12,
    parameter int DW = 32,
    parameter int LW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] param_raddr,
    input  logic [AW-1:0] param_waddr,
    input  logic [LW-1:0] param_iolen,
    output logic          busy,
    output logic          done,
    output logic          mem_re,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic          exp_valid,
    input  logic          exp_ready,
    output logic [DW-1:0] exp_in,
    input  logic          exp_ovalid,
    input  logic [DW-1:0] exp_out,
    output logic          div_valid,
    input  logic          div_ready,
    output logic [DW-1:0] div_num,
    output logic [DW-1:0] div_den,
    input  logic          div_ovalid,
    input  logic [DW-1:0] div_out
);

    typedef enum logic [2:0] {IDLE, MAX, EXP, DIV, DONE} state_t;

    state_t               state;
    logic    [LW-1:0]     n_len;
    logic    [LW-1:0]     rd_left;
    logic    [LW-1:0]     rx_left;
    logic    [LW-1:0]     wr_left;
    logic    [AW-1:0]     rbase;
    logic    [AW-1:0]     wbase;
    logic    [AW-1:0]     rd_addr;
    logic    [AW-1:0]     wr_addr;
    logic signed [DW-1:0] max_val;
    logic    [DW-1:0]     sum;
    logic                 rd_pend;

    logic                 rd_req;
    logic                 wr_req;
    logic signed [DW-1:0] max_nx;
    logic    [DW:0]       sum_wide;
    logic    [DW-1:0]     sum_nx;

    // Reads in EXP/DIV are gated by the unit's ready in the issue cycle itself,
    // so the request is combinational on ready rather than registered.
    always_comb begin
        rd_req = 1'b0;
        wr_req = 1'b0;
        case (state)
            MAX: rd_req = (rd_left != '0);
            EXP: begin
                rd_req = exp_ready && (rd_left != '0);
                wr_req = exp_ovalid;
            end
            DIV: begin
                rd_req = div_ready && (rd_left != '0);
                wr_req = div_ovalid;
            end
            default: begin
                rd_req = 1'b0;
                wr_req = 1'b0;
            end
        endcase
    end

    assign mem_re    = rd_req;
    assign mem_raddr = rd_req ? rd_addr : '0;
    assign mem_we    = wr_req;
    assign mem_waddr = wr_req ? wr_addr : '0;
    assign mem_wdata = !wr_req       ? '0 :
                       (state == EXP) ? exp_out : div_out;

    assign exp_valid = rd_pend && (state == EXP);
    assign exp_in    = exp_valid ? (mem_rdata - max_val) : '0;
    assign div_valid = rd_pend && (state == DIV);
    assign div_num   = div_valid ? mem_rdata : '0;
    assign div_den   = div_valid ? sum : '0;

    assign max_nx   = ((rx_left == n_len) || ($signed(mem_rdata) > max_val)) ? $signed(mem_rdata) : max_val;
    assign sum_wide = {1'b0, sum} + {1'b0, exp_out};
    assign sum_nx   = sum_wide[DW] ? '1 : sum_wide[DW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            n_len   <= '0;
            rd_left <= '0;
            rx_left <= '0;
            wr_left <= '0;
            rbase   <= '0;
            wbase   <= '0;
            rd_addr <= '0;
            wr_addr <= '0;
            max_val <= '0;
            sum     <= '0;
            rd_pend <= 1'b0;
        end else begin
            done    <= 1'b0;
            rd_pend <= rd_req;
            if (rd_req) begin
                rd_addr <= rd_addr + AW'(1);
                rd_left <= rd_left - LW'(1);
            end
            if (wr_req) begin
                wr_addr <= wr_addr + AW'(1);
                wr_left <= wr_left - LW'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        n_len   <= param_iolen;
                        rbase   <= param_raddr;
                        wbase   <= param_waddr;
                        rd_addr <= param_raddr;
                        rd_left <= param_iolen;
                        rx_left <= param_iolen;
                        busy    <= 1'b1;
                        state   <= (param_iolen == '0) ? DONE : MAX;
                    end
                end
                MAX: begin
                    if (rd_pend) begin
                        max_val <= max_nx;
                        rx_left <= rx_left - LW'(1);
                        if (rx_left == LW'(1)) begin
                            state   <= EXP;
                            rd_addr <= rbase;
                            rd_left <= n_len;
                            wr_addr <= wbase;
                            wr_left <= n_len;
                            sum     <= '0;
                        end
                    end
                end
                EXP: begin
                    if (exp_ovalid) begin
                        sum <= sum_nx;
                        if (wr_left == LW'(1)) begin
                            state   <= DIV;
                            rd_addr <= wbase;
                            rd_left <= n_len;
                            wr_addr <= wbase;
                            wr_left <= n_len;
                        end
                    end
                end
                DIV: begin
                    if (div_ovalid && (wr_left == LW'(1))) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_ctrl.sv
// Scoreboard bench for softmax_ctrl: memory and 2-cycle exp/div unit models,
// expected reads/writes/unit inputs queued at start and popped as the DUT produces them.
module tb_softmax_ctrl;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int LW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] param_raddr, param_waddr;
    logic [LW-1:0] param_iolen;
    logic          busy, done;
    logic          mem_re, mem_we;
    logic [AW-1:0] mem_raddr, mem_waddr;
    logic [DW-1:0] mem_rdata, mem_wdata;
    logic          exp_valid, exp_ready, exp_ovalid;
    logic [DW-1:0] exp_in, exp_out;
    logic          div_valid, div_ready, div_ovalid;
    logic [DW-1:0] div_num, div_den, div_out;

    always #5 clk = ~clk;

    softmax_ctrl #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .param_raddr(param_raddr), .param_waddr(param_waddr), .param_iolen(param_iolen),
        .busy(busy), .done(done),
        .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_in(exp_in),
        .exp_ovalid(exp_ovalid), .exp_out(exp_out),
        .div_valid(div_valid), .div_ready(div_ready), .div_num(div_num), .div_den(div_den),
        .div_ovalid(div_ovalid), .div_out(div_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // memory model with a side load port
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          ld_we = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    always @(posedge clk) begin
        if (ld_we) mem[ld_addr] <= ld_data;
        else if (mem_we) mem[mem_waddr] <= mem_wdata;
        mem_rdata <= mem_re ? mem[mem_raddr] : 32'hDEAD_BEEF;
    end

    // exp/div unit models, 2-cycle latency
    logic sat_mode = 1'b0;
    logic tog_mode = 1'b0;
    logic tog_ph   = 1'b0;
    always @(posedge clk) tog_ph <= ~tog_ph;
    assign exp_ready = !tog_mode || tog_ph;
    assign div_ready = !tog_mode || tog_ph;

    function automatic logic [DW-1:0] exp_f(input logic [DW-1:0] x);
        return sat_mode ? 32'hFFFF_FFFF : x + 32'd1000;
    endfunction
    function automatic logic [DW-1:0] div_f(input logic [DW-1:0] num, input logic [DW-1:0] den);
        return {num[15:0], den[15:0]};
    endfunction

    logic          e_v1, e_v2, d_v1, d_v2;
    logic [DW-1:0] e_s1, e_s2, d_s1, d_s2;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e_v1 <= 1'b0; e_v2 <= 1'b0; d_v1 <= 1'b0; d_v2 <= 1'b0;
            e_s1 <= '0; e_s2 <= '0; d_s1 <= '0; d_s2 <= '0;
        end else begin
            e_v1 <= exp_valid; e_s1 <= exp_f(exp_in);
            e_v2 <= e_v1;      e_s2 <= e_s1;
            d_v1 <= div_valid; d_s1 <= div_f(div_num, div_den);
            d_v2 <= d_v1;      d_s2 <= d_s1;
        end
    end
    assign exp_ovalid = e_v2;
    assign exp_out    = e_s2;
    assign div_ovalid = d_v2;
    assign div_out    = d_s2;

    // scoreboard
    logic [AW-1:0]    rq[$];
    logic [DW-1:0]    eq[$];
    logic [DW-1:0]    dq[$];
    logic [AW+DW-1:0] wq[$];
    logic [DW-1:0]    exp_den;
    int rd_seen = 0, we_cnt = 0, done_cnt = 0;
    int rd_base = 0, we_base = 0, done_base = 0, cur_n = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_re) begin
                if (rq.size() == 0) check("re_extra", 1, 0);
                else check("raddr", mem_raddr, rq.pop_front());
                if (rd_seen - rd_base >= cur_n && rd_seen - rd_base < 2 * cur_n)
                    check("re_exp_ready", exp_ready, 1);
                else if (rd_seen - rd_base >= 2 * cur_n)
                    check("re_div_ready", div_ready, 1);
                rd_seen++;
            end
            if (mem_we) begin
                if (wq.size() == 0) check("we_extra", 1, 0);
                else begin
                    logic [AW+DW-1:0] w;
                    w = wq.pop_front();
                    check("waddr", mem_waddr, w[AW+DW-1:DW]);
                    check("wdata", mem_wdata, w[DW-1:0]);
                end
                we_cnt++;
            end
            if (exp_valid) begin
                if (eq.size() == 0) check("exp_extra", 1, 0);
                else check("exp_in", exp_in, eq.pop_front());
            end
            if (div_valid) begin
                if (dq.size() == 0) check("div_extra", 1, 0);
                else check("div_num", div_num, dq.pop_front());
                check("div_den", div_den, exp_den);
            end
            if (done) done_cnt++;
        end
    end

    logic [DW-1:0] dat [0:63];

    task automatic prep_and_start(input int n, input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                                  input logic sat, input logic tog, input logic extra_start);
        logic [DW-1:0] m, ein, eo;
        logic [63:0]   s64;
        logic [DW-1:0] eo_list [0:63];
        sat_mode = sat;
        tog_mode = tog;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            ld_we = 1'b1; ld_addr = ra + AW'(k); ld_data = dat[k];
        end
        @(negedge clk);
        ld_we = 1'b0;
        m = dat[0];
        for (int k = 1; k < n; k++) if ($signed(dat[k]) > $signed(m)) m = dat[k];
        s64 = 64'd0;
        for (int k = 0; k < n; k++) begin
            ein = dat[k] - m;
            eq.push_back(ein);
            eo = exp_f(ein);
            eo_list[k] = eo;
            s64 = s64 + {32'd0, eo};
            if (s64 > 64'h0000_0000_FFFF_FFFF) s64 = 64'h0000_0000_FFFF_FFFF;
            wq.push_back({wa + AW'(k), eo});
            dq.push_back(eo);
        end
        exp_den = s64[DW-1:0];
        for (int k = 0; k < n; k++) wq.push_back({wa + AW'(k), div_f(eo_list[k], exp_den)});
        for (int k = 0; k < n; k++) rq.push_back(ra + AW'(k));
        for (int k = 0; k < n; k++) rq.push_back(ra + AW'(k));
        for (int k = 0; k < n; k++) rq.push_back(wa + AW'(k));
        cur_n = n; rd_base = rd_seen; we_base = we_cnt; done_base = done_cnt;
        @(negedge clk);
        param_raddr = ra; param_waddr = wa; param_iolen = LW'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        if (extra_start) begin
            repeat (2) @(negedge clk);
            param_raddr = 12'h555; param_waddr = 12'h666; param_iolen = '0; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic finish_case(input int n);
        int lat;
        lat = 0;
        while (!done && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        check("done_seen", done, 1);
        if (n == 0) check("n0_latency", lat, 1);
        @(negedge clk);
        check("done_one_pulse", done, 0);
        check("busy_idle", busy, 0);
        check("done_count", done_cnt - done_base, 1);
        check("reads", rd_seen - rd_base, 3 * n);
        check("writes", we_cnt - we_base, 2 * n);
        check("rq_empty", rq.size(), 0);
        check("wq_empty", wq.size(), 0);
        check("eq_empty", eq.size(), 0);
        check("dq_empty", dq.size(), 0);
    endtask

    task automatic load_base();
        dat[0] = 32'd1; dat[1] = 32'd3; dat[2] = -32'sd2; dat[3] = 32'd3;
    endtask

    initial begin
        int t;
        rst = 1'b1; start = 1'b0;
        param_raddr = '0; param_waddr = '0; param_iolen = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_re", mem_re, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_exp_valid", exp_valid, 0);
        check("rst_div_valid", div_valid, 0);
        check("rst_addrs", {mem_raddr, mem_waddr}, 0);
        check("rst_data", {mem_wdata, exp_in, div_num, div_den}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // basic N=4
        load_base();
        prep_and_start(4, 12'h010, 12'h080, 1'b0, 1'b0, 1'b0);
        finish_case(4);

        // N=0
        prep_and_start(0, 12'h020, 12'h090, 1'b0, 1'b0, 1'b0);
        finish_case(0);

        // toggling ready, same data
        load_base();
        prep_and_start(4, 12'h010, 12'h0A0, 1'b0, 1'b1, 1'b0);
        finish_case(4);

        // saturating sum
        dat[0] = 32'd5; dat[1] = 32'd6; dat[2] = 32'd7;
        prep_and_start(3, 12'h040, 12'h300, 1'b1, 1'b0, 1'b0);
        finish_case(3);

        // read address wrap, all negative data
        dat[0] = -32'sd7; dat[1] = -32'sd3; dat[2] = -32'sd9; dat[3] = -32'sd100;
        prep_and_start(4, 12'hFFE, 12'h100, 1'b0, 1'b0, 1'b0);
        finish_case(4);

        // random data with an ignored start while busy
        for (int k = 0; k < 8; k++) dat[k] = $urandom_range(0, 2000) - 1000;
        prep_and_start(8, 12'h400, 12'h600, 1'b0, 1'b1, 1'b1);
        finish_case(8);

        // abort in EXP after two writes
        load_base();
        prep_and_start(4, 12'h010, 12'h0C0, 1'b0, 1'b0, 1'b0);
        t = 0;
        while (we_cnt - we_base < 2 && t < 2000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("abort_reached_2_writes", we_cnt - we_base, 2);
        @(posedge clk);
        #1 rst = 1'b1;
        rq.delete(); wq.delete(); eq.delete(); dq.delete();
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_mem_we", mem_we, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_writes", we_cnt - we_base, 2);
        check("abort_no_done", done_cnt - done_base, 0);
        check("abort_idle", busy, 0);

        // recovery after abort
        load_base();
        prep_and_start(4, 12'h010, 12'h080, 1'b0, 1'b0, 1'b0);
        finish_case(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
